// File: rtl/mt_controller.sv
// ---------------------------------------------------------------------------
// mt_controller
//   Front-end for the mersenne_twister core. After reset (or on request) it
//   expands a 32-bit seed into the 624-word MT19937 state and streams it into
//   the core's load port. Once seeded, it shares the core's generate port
//   among NUM_REQ requesters using round-robin arbitration.
//
// Ports
//   clk, rst        : single clock; synchronous active-high reset
//   seed_valid/seed : new seed offered; taken when seed_ready is high
//   seed_ready      : high while idle in ARB
//   seeded          : core holds a complete state
//   req / ack       : level requests / one-hot single-cycle grant pulses
//   rv_out          : last delivered random value, held between acks
//   mt_load_value   : core load strobe, one state word per cycle
//   mt_value        : state word presented to the core
//   mt_gen_rv       : core generate strobe
//   mt_rv           : core output, valid the cycle after mt_gen_rv
// ---------------------------------------------------------------------------
module mt_controller #(
   parameter int           W            = 32,
   parameter int           N            = 624,
   parameter int           NUM_REQ      = 4,
   parameter logic [W-1:0] DEFAULT_SEED = 32'd5489
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               seed_valid,
   input  logic [W-1:0]       seed,
   output logic               seed_ready,
   output logic               seeded,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] ack,
   output logic [W-1:0]       rv_out,
   output logic               mt_load_value,
   output logic [W-1:0]       mt_value,
   output logic               mt_gen_rv,
   input  logic [W-1:0]       mt_rv
);

   localparam int           KW   = $clog2(N);
   localparam int           PW   = $clog2(NUM_REQ);
   localparam logic [W-1:0] MT_F = W'(1812433253);

   typedef enum logic [1:0] {S_SEED, S_ARB, S_GEN, S_CAPTURE} state_e;

   typedef struct packed {
      logic          hit;
      logic [PW-1:0] idx;
   } grant_t;

   state_e               st_q;
   logic [KW-1:0]        k_q;
   logic [W-1:0]         x_q;       // current state word x_k (holds the seed at k=0)
   logic [PW-1:0]        ptr_q;
   logic [PW-1:0]        gnt_q;
   logic [NUM_REQ-1:0]   ack_q;
   logic [W-1:0]         rv_q;
   logic                 seeded_q;

   logic [W-1:0]         x_mix;
   logic [W-1:0]         x_d;
   grant_t               arb_d;
   logic [PW:0]          cand;
   logic [PW-1:0]        ptr_d;
   logic [NUM_REQ-1:0]   gnt_oh;

   // Seed expansion: x_{k+1} = F * (x_k ^ (x_k >> 30)) + (k+1), low W bits.
   always_comb begin
      x_mix = x_q ^ (x_q >> 30);
      x_d   = MT_F * x_mix + W'(k_q) + W'(1);
   end

   // First asserted request at or after the pointer, wrapping modulo NUM_REQ.
   // cand carries one extra bit so ptr+off never overflows before the wrap.
   always_comb begin
      arb_d = '0;
      cand  = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand = {1'b0, ptr_q} + (PW+1)'(off);
         if (cand >= (PW+1)'(NUM_REQ)) cand = cand - (PW+1)'(NUM_REQ);
         if (!arb_d.hit && req[cand[PW-1:0]]) begin
            arb_d.hit = 1'b1;
            arb_d.idx = cand[PW-1:0];
         end
      end
      ptr_d = (arb_d.idx == PW'(NUM_REQ-1)) ? '0 : arb_d.idx + PW'(1);
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_oh
      assign gnt_oh[i] = (gnt_q == PW'(i));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q     <= S_SEED;
         k_q      <= '0;
         x_q      <= DEFAULT_SEED;
         ptr_q    <= '0;
         gnt_q    <= '0;
         ack_q    <= '0;
         rv_q     <= '0;
         seeded_q <= 1'b0;
      end else begin
         ack_q <= '0;
         case (st_q)
            S_SEED: begin
               x_q <= x_d;
               if (k_q == KW'(N-1)) begin
                  k_q      <= '0;
                  seeded_q <= 1'b1;
                  st_q     <= S_ARB;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            S_ARB: begin
               // A pending seed beats any request in the same cycle.
               if (seed_valid) begin
                  x_q      <= seed;
                  k_q      <= '0;
                  seeded_q <= 1'b0;
                  st_q     <= S_SEED;
               end else if (arb_d.hit) begin
                  gnt_q <= arb_d.idx;
                  ptr_q <= ptr_d;
                  st_q  <= S_GEN;
               end
            end
            S_GEN: begin
               st_q <= S_CAPTURE;
            end
            S_CAPTURE: begin
               // Acked even if the requester has dropped req: the core has
               // already advanced, so the value must be consumed here.
               rv_q  <= mt_rv;
               ack_q <= gnt_oh;
               st_q  <= S_ARB;
            end
         endcase
      end
   end

   // Strobes decode the current state; rst forces every output low at once.
   assign mt_load_value = ~rst & (st_q == S_SEED);
   assign mt_value      = mt_load_value ? x_q : '0;
   assign mt_gen_rv     = ~rst & (st_q == S_GEN);
   assign seed_ready    = ~rst & (st_q == S_ARB);
   assign seeded        = ~rst & seeded_q;
   assign ack           = rst ? '0 : ack_q;
   assign rv_out        = rst ? '0 : rv_q;

endmodule

// File: tb/tb_mt_controller.sv
module tb_mt_controller;
   localparam int NR = 4;
   typedef logic [31:0] mtst_t [624];

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          seed_valid = 1'b0;
   logic [31:0]   seed = '0;
   logic [NR-1:0] req = '0;
   logic          seed_ready, seeded, mt_load_value, mt_gen_rv;
   logic [NR-1:0] ack;
   logic [31:0]   rv_out, mt_value;
   logic [31:0]   mt_rv = '0;

   always #5 clk = ~clk;

   mt_controller #(.W(32), .N(624), .NUM_REQ(NR), .DEFAULT_SEED(32'd5489)) dut (
      .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed),
      .seed_ready(seed_ready), .seeded(seeded), .req(req), .ack(ack),
      .rv_out(rv_out), .mt_load_value(mt_load_value), .mt_value(mt_value),
      .mt_gen_rv(mt_gen_rv), .mt_rv(mt_rv)
   );

   int          n_cmp = 0, n_bad = 0;
   int          m_ptr = 0;   // model round-robin pointer
   int          ncons = 0;   // values consumed since last seeding
   logic [31:0] ref_out [32];

   // MT19937 output r (0-based, r < 624) from a freshly initialised state.
   function automatic logic [31:0] mt_out(input mtst_t s, input int r);
      mtst_t       t;
      logic [31:0] y, v;
      t = s;
      for (int i = 0; i < 624; i++) begin
         y = (t[i] & 32'h8000_0000) | (t[(i+1)%624] & 32'h7FFF_FFFF);
         v = t[(i+397)%624] ^ (y >> 1);
         if (y[0]) v = v ^ 32'h9908_B0DF;
         t[i] = v;
      end
      y = t[r];
      y = y ^ (y >> 11);
      y = y ^ ((y << 7) & 32'h9D2C_5680);
      y = y ^ ((y << 15) & 32'hEFC6_0000);
      y = y ^ (y >> 18);
      return y;
   endfunction

   task automatic ref_fill(input logic [31:0] s);
      mtst_t a;
      a[0] = s;
      for (int k = 1; k < 624; k++)
         a[k] = 32'd1812433253 * (a[k-1] ^ (a[k-1] >> 30)) + 32'(k);
      for (int n = 0; n < 32; n++) ref_out[n] = mt_out(a, n);
      ncons = 0;
   endtask

   // Attached core: captures streamed words, answers generate strobes one
   // cycle later with the next value of its stream.
   mtst_t core_st;
   int    core_w, core_r;
   logic  core_prev;
   always @(posedge clk) begin
      if (rst) begin
         core_w    <= 0;
         core_r    <= 0;
         core_prev <= 1'b0;
      end else begin
         core_prev <= mt_load_value;
         if (mt_load_value) begin
            if (core_prev) begin
               if (core_w < 624) core_st[core_w] <= mt_value;
               core_w <= core_w + 1;
            end else begin
               core_st[0] <= mt_value;
               core_w     <= 1;
            end
            core_r <= 0;
         end
         if (mt_gen_rv) begin
            mt_rv  <= mt_out(core_st, core_r);
            core_r <= core_r + 1;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Spec-level round-robin: first set bit at or after the pointer.
   task automatic model_grant(input logic [NR-1:0] pat, output logic [NR-1:0] oh);
      int g;
      g = -1;
      for (int off = 0; off < NR; off++)
         if (g < 0 && pat[(m_ptr+off)%NR]) g = (m_ptr + off) % NR;
      oh = '0;
      if (g >= 0) begin
         oh[g] = 1'b1;
         m_ptr = (g + 1) % NR;
      end
   endtask

   // Called in the first load cycle; walks the load burst to its end.
   task automatic wait_loads(input logic [31:0] s0, output int cnt, output logic [31:0] v0,
                             output logic [31:0] v1, output int bad_words, output int side);
      logic [31:0] ex;
      ex = s0; cnt = 0; v0 = '0; v1 = '0; bad_words = 0; side = 0;
      while (mt_load_value === 1'b1 && cnt < 700) begin
         if (cnt == 0) v0 = mt_value;
         if (cnt == 1) v1 = mt_value;
         if (mt_value !== ex) bad_words++;
         if (ack !== '0 || mt_gen_rv !== 1'b0 || seeded !== 1'b0 || seed_ready !== 1'b0) side++;
         cnt++;
         ex = 32'd1812433253 * (ex ^ (ex >> 30)) + 32'(cnt);
         step();
      end
   endtask

   // Called in an ARB cycle; holds pat until ack (or timeout).
   task automatic do_req(input logic [NR-1:0] pat, input int drop_at, output logic [NR-1:0] a,
                         output logic [31:0] r, output int lat, output int gens);
      req = pat; lat = 0; gens = 0; a = '0; r = '0;
      while (lat < 20) begin
         step();
         lat++;
         if (mt_gen_rv === 1'b1) gens++;
         if (lat == drop_at) req = '0;
         if (ack !== '0) begin
            a = ack;
            r = rv_out;
            break;
         end
      end
   endtask

   task automatic chk_loads(input string nm, input int cnt, input int bad, input int side);
      n_cmp++; if (cnt !== 624) begin n_bad++; $display("FAIL %s_count: got %0d want 624", nm, cnt); end
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL %s_words: %0d wrong words want 0", nm, bad); end
      n_cmp++; if (side !== 0) begin n_bad++; $display("FAIL %s_side: %0d cycles with ack/gen/ready want 0", nm, side); end
      n_cmp++; if (seeded !== 1'b1 || seed_ready !== 1'b1) begin n_bad++;
         $display("FAIL %s_ready: seeded=%b seed_ready=%b want 1 1", nm, seeded, seed_ready); end
   endtask

   task automatic test_reset();
      int cnt, bad, side;
      logic [31:0] v0, v1;
      rst = 1'b1; req = '0; seed_valid = 1'b0;
      repeat (3) step();
      n_cmp++;
      if ({ack, rv_out, seeded, seed_ready, mt_load_value, mt_gen_rv, mt_value} !== '0) begin
         n_bad++; $display("FAIL reset_outputs: ack=%b rv=%h sd=%b rdy=%b ld=%b gen=%b val=%h want all 0",
                           ack, rv_out, seeded, seed_ready, mt_load_value, mt_gen_rv, mt_value);
      end
      rst = 1'b0; #1;
      ref_fill(32'd5489); m_ptr = 0;
      wait_loads(32'd5489, cnt, v0, v1, bad, side);
      chk_loads("reset", cnt, bad, side);
      n_cmp++; if (v0 !== 32'h0000_1571) begin n_bad++; $display("FAIL reset_word0: got %h want 00001571", v0); end
      n_cmp++; if (v1 !== 32'h4D98_EE96) begin n_bad++; $display("FAIL reset_word1: got %h want 4d98ee96", v1); end
   endtask

   task automatic test_single();
      logic [NR-1:0] a, ex;
      logic [31:0]   r;
      int            lat, gens;
      model_grant(4'b0100, ex);
      do_req(4'b0100, -1, a, r, lat, gens);
      n_cmp++; if (a !== ex) begin n_bad++; $display("FAIL single_ack: got %b want %b", a, ex); end
      n_cmp++; if (lat !== 3 || gens !== 1) begin n_bad++; $display("FAIL single_timing: lat=%0d gens=%0d want 3 1", lat, gens); end
      n_cmp++; if (r !== 32'hD091_BB5C) begin n_bad++; $display("FAIL single_rv: got %h want d091bb5c", r); end
      ncons++;
      req = '0;
      step();
      n_cmp++; if (ack !== '0 || rv_out !== r) begin n_bad++;
         $display("FAIL single_hold: ack=%b rv=%h want 0000 %h", ack, rv_out, r); end
   endtask

   task automatic test_back_to_back();
      logic [NR-1:0] ord [5];
      logic [NR-1:0] a, ex;
      logic [31:0]   r;
      int            cnt, bad, side, lat, gens;
      logic [31:0]   v0, v1;
      ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rst = 1'b1; step(); step(); rst = 1'b0; #1;
      ref_fill(32'd5489); m_ptr = 0;
      wait_loads(32'd5489, cnt, v0, v1, bad, side);
      chk_loads("b2b_seed", cnt, bad, side);
      for (int i = 0; i < 5; i++) begin
         model_grant(4'b1111, ex);
         do_req(4'b1111, -1, a, r, lat, gens);
         n_cmp++; if (a !== ord[i] || a !== ex) begin n_bad++; $display("FAIL b2b_ack%0d: got %b want %b", i, a, ord[i]); end
         n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL b2b_spacing%0d: got %0d want 3", i, lat); end
         n_cmp++; if (r !== ref_out[ncons]) begin n_bad++; $display("FAIL b2b_rv%0d: got %h want %h", i, r, ref_out[ncons]); end
         ncons++;
      end
      req = '0;
   endtask

   task automatic test_seed_vs_req();
      logic [NR-1:0] a, ex;
      logic [31:0]   r, v0, v1;
      int            cnt, bad, side, lat, gens;
      seed_valid = 1'b1; seed = 32'd1; req = 4'b0001;
      step();
      seed_valid = 1'b0;
      wait_loads(32'd1, cnt, v0, v1, bad, side);
      chk_loads("seedwin", cnt, bad, side);
      n_cmp++; if (v0 !== 32'd1) begin n_bad++; $display("FAIL seedwin_word0: got %h want 00000001", v0); end
      ref_fill(32'd1);
      model_grant(4'b0001, ex);
      do_req(4'b0001, -1, a, r, lat, gens);
      n_cmp++; if (a !== ex || lat !== 3) begin n_bad++; $display("FAIL seedwin_ack: got %b lat %0d want %b lat 3", a, lat, ex); end
      n_cmp++; if (r !== 32'd1791095845) begin n_bad++; $display("FAIL seedwin_rv: got %0d want 1791095845", r); end
      ncons++;
      req = '0;
   endtask

   task automatic test_reset_mid_seed();
      logic [31:0] ex, v0, v1;
      int          bad, cnt, side;
      rst = 1'b1; step(); rst = 1'b0; #1;
      ex = 32'd5489; bad = 0;
      for (int k = 0; k < 300; k++) begin
         if (mt_load_value !== 1'b1 || mt_value !== ex) bad++;
         ex = 32'd1812433253 * (ex ^ (ex >> 30)) + 32'(k + 1);
         step();
      end
      n_cmp++; if (bad !== 0 || mt_load_value !== 1'b1 || mt_value !== ex) begin n_bad++;
         $display("FAIL midseed_k300: ld=%b val=%h bad=%0d want 1 %h 0", mt_load_value, mt_value, bad, ex); end
      rst = 1'b1;
      step();
      n_cmp++;
      if ({ack, rv_out, seeded, seed_ready, mt_load_value, mt_gen_rv, mt_value} !== '0) begin
         n_bad++; $display("FAIL midseed_zero: ld=%b val=%h rv=%h sd=%b want all 0", mt_load_value, mt_value, rv_out, seeded);
      end
      rst = 1'b0; #1;
      ref_fill(32'd5489); m_ptr = 0;
      wait_loads(32'd5489, cnt, v0, v1, bad, side);
      chk_loads("midseed", cnt, bad, side);
      n_cmp++; if (v0 !== 32'h0000_1571) begin n_bad++; $display("FAIL midseed_word0: got %h want 00001571", v0); end
   endtask

   task automatic test_withdraw();
      logic [NR-1:0] a, ex;
      logic [31:0]   r;
      int            lat, gens;
      model_grant(4'b0010, ex);
      do_req(4'b0010, 1, a, r, lat, gens);
      n_cmp++; if (a !== ex || gens !== 1) begin n_bad++; $display("FAIL withdraw_ack: got %b gens %0d want %b 1", a, gens, ex); end
      n_cmp++; if (r !== ref_out[ncons]) begin n_bad++; $display("FAIL withdraw_rv: got %h want %h", r, ref_out[ncons]); end
      ncons++;
      model_grant(4'b0001, ex);
      do_req(4'b0001, -1, a, r, lat, gens);
      n_cmp++; if (a !== ex) begin n_bad++; $display("FAIL withdraw_next_ack: got %b want %b", a, ex); end
      n_cmp++; if (r !== ref_out[ncons]) begin n_bad++; $display("FAIL withdraw_next_rv: got %h want %h (output 2)", r, ref_out[ncons]); end
      ncons++;
      req = '0;
   endtask

   task automatic test_random();
      logic [NR-1:0] a, ex, pat;
      logic [31:0]   r, s, v0, v1;
      int            cnt, bad, side, lat, gens, idle, idle_bad;
      s = $urandom;
      seed_valid = 1'b1; seed = s;
      step();
      seed_valid = 1'b0;
      wait_loads(s, cnt, v0, v1, bad, side);
      chk_loads("rand_seed", cnt, bad, side);
      ref_fill(s);
      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            req = '0; idle_bad = 0;
            idle = $urandom_range(1, 4);
            repeat (idle) begin
               step();
               if (ack !== '0 || mt_gen_rv !== 1'b0 || seed_ready !== 1'b1) idle_bad++;
            end
            n_cmp++; if (idle_bad !== 0) begin n_bad++; $display("FAIL rand_idle%0d: %0d bad cycles want 0", i, idle_bad); end
         end
         pat = NR'($urandom_range(1, (1 << NR) - 1));
         model_grant(pat, ex);
         do_req(pat, -1, a, r, lat, gens);
         n_cmp++; if (a !== ex || lat !== 3 || gens !== 1) begin n_bad++;
            $display("FAIL rand_ack%0d: req %b got %b lat %0d gens %0d want %b 3 1", i, pat, a, lat, gens, ex); end
         n_cmp++; if (r !== ref_out[ncons]) begin n_bad++; $display("FAIL rand_rv%0d: got %h want %h", i, r, ref_out[ncons]); end
         ncons++;
      end
      req = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_seed_vs_req();
      test_reset_mid_seed();
      test_withdraw();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
